// File: rtl/cmd_dispatch_pkg.sv
// rtl/cmd_dispatch_pkg.sv - shared header layout, FSM encoding and response word format
package cmd_dispatch_pkg;

    localparam int RSP_WIDTH     = 33;
    localparam int LAST_BIT      = 32;
    localparam int HDR_NARGS_LSB = 8;
    localparam int HDR_NARGS_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_INVOL
    } state_t;

    function automatic logic [HDR_NARGS_W-1:0] hdr_nargs(input logic [31:0] word);
        return word[HDR_NARGS_LSB +: HDR_NARGS_W];
    endfunction

endpackage

// File: rtl/cmd_dispatch_rsp_fifo.sv
// rtl/cmd_dispatch_rsp_fifo.sv - synchronous response FIFO toward the host framer
module rsp_fifo
    import cmd_dispatch_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [RSP_WIDTH-1:0] s_tdata,
    input  logic                 s_tvalid,
    output logic [RSP_WIDTH-1:0] m_tdata,
    input  logic                 m_tready,
    output logic                 full,
    output logic                 empty
);
    localparam int AW = $clog2(DEPTH);

    logic [RSP_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 pop;
    logic                 push;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && m_tready;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push
    assign push  = s_tvalid && (!full || pop);
    assign m_tdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= s_tdata;
    end

endmodule

// File: rtl/cmd_dispatch.sv
// rtl/cmd_dispatch.sv - host command dispatcher: collect args, issue to units, gather responses
module cmd_dispatch
    import cmd_dispatch_pkg::*;
#(
    parameter int CMD_BITS  = 6,
    parameter int NUNITS    = 4,
    parameter int MAX_ARGS  = 8,
    parameter int RSP_DEPTH = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [31:0]                 in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [CMD_BITS-1:0]         cmd,
    output logic                        cmd_ready,
    output logic [31:0]                 arg_data,
    input  logic [NUNITS-1:0]           arg_advance,
    input  logic [NUNITS-1:0]           cmd_done,
    input  logic [RSP_WIDTH*NUNITS-1:0] param_data,
    input  logic [NUNITS-1:0]           param_write,
    input  logic [NUNITS-1:0]           invol_req,
    output logic [NUNITS-1:0]           invol_grant,
    output logic [RSP_WIDTH-1:0]        rsp_data,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        err_timeout,
    output logic                        err_overflow
);
    localparam int AW = $clog2(MAX_ARGS);
    localparam int UW = $clog2(NUNITS);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t                 state;
    logic [HDR_NARGS_W-1:0] nargs;
    logic [HDR_NARGS_W-1:0] cnt;
    logic [HDR_NARGS_W-1:0] arg_ptr;
    logic [HDR_NARGS_W-1:0] hdr_n;
    logic                   discard;
    logic [31:0]            args [MAX_ARGS];
    logic [TW-1:0]          tmo;
    logic [UW-1:0]          rr_ptr;
    logic [UW-1:0]          pick_idx;
    logic                   pick_any;
    logic                   issuing;
    logic [RSP_WIDTH-1:0]   wr_word;
    logic                   wr_ok;
    logic                   rsp_drop;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign hdr_n    = hdr_nargs(in_data);
    assign issuing  = (state == ST_ISSUE) || (state == ST_WAIT_DONE);
    assign arg_data = (issuing && arg_ptr < nargs) ? args[arg_ptr[AW-1:0]] : 32'd0;

    // Round-robin search begins with the unit after the last one granted
    always_comb begin
        int idx;
        pick_any = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int i = NUNITS; i >= 1; i--) begin
            idx = (int'(rr_ptr) + i) % NUNITS;
            if (invol_req[UW'(idx)]) begin
                pick_any = 1'b1;
                pick_idx = UW'(idx);
            end
        end
    end

    always_comb begin
        wr_word = '0;
        for (int u = 0; u < NUNITS; u++) begin
            if (param_write[u]) wr_word = wr_word | param_data[u*RSP_WIDTH +: RSP_WIDTH];
        end
    end

    assign wr_ok = ((state == ST_WAIT_DONE) && $onehot(param_write)) ||
                   ((state == ST_INVOL) && (invol_grant != '0) && (param_write == invol_grant));
    assign rsp_drop = ((param_write != '0) && !wr_ok) || (wr_ok && fifo_full && !rsp_ready);
    assign rsp_valid = !fifo_empty;

    rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tdata  (wr_word),
        .s_tvalid (wr_ok),
        .m_tdata  (rsp_data),
        .m_tready (rsp_ready),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (state == ST_COLLECT && in_valid && in_ready && !discard)
            args[cnt[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b0;
            cmd          <= '0;
            cmd_ready    <= 1'b0;
            nargs        <= '0;
            cnt          <= '0;
            arg_ptr      <= '0;
            discard      <= 1'b0;
            tmo          <= '0;
            rr_ptr       <= '0;
            invol_grant  <= '0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            cmd_ready <= 1'b0;
            if (rsp_drop) err_overflow <= 1'b1;
            if (issuing && (arg_advance != '0) && arg_ptr < nargs) arg_ptr <= arg_ptr + 1'b1;
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        nargs   <= hdr_n;
                        cnt     <= '0;
                        arg_ptr <= '0;
                        if (int'(hdr_n) > MAX_ARGS) begin
                            discard      <= 1'b1;
                            err_overflow <= 1'b1;
                            state        <= ST_COLLECT;
                        end else begin
                            discard <= 1'b0;
                            cmd     <= in_data[CMD_BITS-1:0];
                            if (hdr_n == '0) begin
                                state     <= ST_ISSUE;
                                cmd_ready <= 1'b1;
                                in_ready  <= 1'b0;
                            end else begin
                                state <= ST_COLLECT;
                            end
                        end
                    end else if (!in_valid && (invol_req != '0)) begin
                        state    <= ST_INVOL;
                        in_ready <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (in_valid && in_ready) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == nargs - 1'b1) begin
                            if (discard) begin
                                state <= ST_IDLE;
                            end else begin
                                state     <= ST_ISSUE;
                                cmd_ready <= 1'b1;
                                in_ready  <= 1'b0;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    tmo   <= TW'(TIMEOUT);
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (cmd_done != '0) begin
                        state    <= ST_IDLE;
                        in_ready <= 1'b1;
                    end else if (tmo == TW'(1)) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                        in_ready    <= 1'b1;
                    end else begin
                        tmo <= tmo - 1'b1;
                    end
                end
                ST_INVOL: begin
                    if (invol_grant == '0) begin
                        if (pick_any) begin
                            invol_grant <= NUNITS'(1) << pick_idx;
                            rr_ptr      <= pick_idx;
                        end else begin
                            state    <= ST_IDLE;
                            in_ready <= 1'b1;
                        end
                    end else if ((invol_req & invol_grant) == '0) begin
                        invol_grant <= '0;
                        state       <= ST_IDLE;
                        in_ready    <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_dispatch.sv
// tb/tb_cmd_dispatch.sv - directed self-checking bench for cmd_dispatch
module tb_cmd_dispatch;
    import cmd_dispatch_pkg::*;

    localparam int NU    = 4;
    localparam int TMO   = 1024;
    localparam int DEPTH = 16;

    logic                    clk;
    logic                    rst_n;
    logic [31:0]             in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [5:0]              cmd;
    logic                    cmd_ready;
    logic [31:0]             arg_data;
    logic [NU-1:0]           arg_advance;
    logic [NU-1:0]           cmd_done;
    logic [RSP_WIDTH*NU-1:0] param_data;
    logic [NU-1:0]           param_write;
    logic [NU-1:0]           invol_req;
    logic [NU-1:0]           invol_grant;
    logic [RSP_WIDTH-1:0]    rsp_data;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic                    err_timeout;
    logic                    err_overflow;

    int n_chk = 0;
    int n_err = 0;
    logic [32:0] w [3];

    cmd_dispatch #(
        .CMD_BITS(6), .NUNITS(NU), .MAX_ARGS(8), .RSP_DEPTH(DEPTH), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cmd(cmd), .cmd_ready(cmd_ready), .arg_data(arg_data),
        .arg_advance(arg_advance), .cmd_done(cmd_done),
        .param_data(param_data), .param_write(param_write),
        .invol_req(invol_req), .invol_grant(invol_grant),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .err_timeout(err_timeout), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put_hdr(input int c, input int n);
        in_data  = {16'h0, 8'(n), 8'(c)};
        in_valid = 1'b1;
    endtask

    task automatic pw(input int u, input logic [32:0] d);
        param_data[u*RSP_WIDTH +: RSP_WIDTH] = d;
        param_write = NU'(1) << u;
    endtask

    initial begin
        clk = 0; rst_n = 0; in_data = 0; in_valid = 0; arg_advance = 0; cmd_done = 0;
        param_data = 0; param_write = 0; invol_req = 0; rsp_ready = 0;
        tick; tick;
        check("rst_in_ready", in_ready, 0);
        check("rst_cmd", cmd, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_arg_data", arg_data, 0);
        check("rst_grant", invol_grant, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_err_tmo", err_timeout, 0);
        check("rst_err_ovf", err_overflow, 0);
        rst_n = 1; tick;
        check("idle_rdy", in_ready, 1);

        // cmd 5 with four arguments, unit streams them out
        put_hdr(5, 4); tick;
        check("collect_rdy", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hA + i; tick;
            if (i < 3) check("collect_no_issue", cmd_ready, 0);
        end
        in_valid = 0;
        check("issue_pulse", cmd_ready, 1);
        check("issue_cmd", cmd, 5);
        check("issue_busy", in_ready, 0);
        check("arg0", arg_data, 32'hA);
        arg_advance = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            tick;
            check("arg_seq", arg_data, (i < 3) ? 32'hB + i : 32'h0);
            check("pulse_once", cmd_ready, 0);
        end
        arg_advance = 0; cmd_done = 4'b0001; tick; cmd_done = 0;
        check("done_idle", in_ready, 1);

        // zero-argument command plus a three word response from unit 2
        put_hdr(3, 0); tick; in_valid = 0;
        check("n0_pulse", cmd_ready, 1);
        check("n0_arg", arg_data, 0);
        check("n0_cmd", cmd, 3);
        tick;
        w[0] = 33'h0_1111_0001; w[1] = 33'h0_1111_0002; w[2] = {1'b1, 32'h1111_0003};
        for (int i = 0; i < 3; i++) begin pw(2, w[i]); tick; end
        param_write = 0;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_head", rsp_data, w[0]);
        tick;
        check("rsp_hold", rsp_data, w[0]);
        cmd_done = 4'b0100; tick; cmd_done = 0;
        rsp_ready = 1;
        for (int i = 0; i < 3; i++) begin check("rsp_drain", rsp_data, w[i]); tick; end
        rsp_ready = 0;
        check("rsp_empty", rsp_valid, 0);
        check("no_ovf", err_overflow, 0);

        // timeout
        put_hdr(7, 0); tick; in_valid = 0;
        check("tmo_issue", cmd_ready, 1);
        repeat (TMO - 1) tick;
        check("tmo_early", err_timeout, 0);
        repeat (3) tick;
        check("tmo_set", err_timeout, 1);
        check("tmo_idle", in_ready, 1);
        cmd_done = 4'b0001; tick; cmd_done = 0;
        check("late_done", in_ready, 1);
        put_hdr(8, 0); tick; in_valid = 0;
        check("post_tmo_issue", cmd_ready, 1);
        tick; cmd_done = 4'b0001; tick; cmd_done = 0;

        // involuntary arbitration, header waits during INVOL
        invol_req = 4'b1010; tick;
        check("grant_lat", invol_grant, 0);
        tick;
        check("grant_u1", invol_grant, 4'b0010);
        pw(1, 33'h0_0000_00AB); tick; param_write = 0;
        check("invol_wr", rsp_valid, 1);
        check("invol_no_ovf", err_overflow, 0);
        put_hdr(9, 0); tick;
        check("hdr_wait", in_ready, 0);
        check("hdr_wait_grant", invol_grant, 4'b0010);
        invol_req = 4'b1000; tick;
        check("grant_drop", invol_grant, 0);
        check("grant_drop_rdy", in_ready, 1);
        tick; in_valid = 0;
        check("hdr_prio", cmd_ready, 1);
        check("hdr_prio_cmd", cmd, 9);
        tick; cmd_done = 4'b1000; tick; cmd_done = 0;
        tick; tick;
        check("grant_u3", invol_grant, 4'b1000);
        invol_req = 0; tick;
        check("grant_u3_drop", invol_grant, 0);
        rsp_ready = 1;
        check("invol_word", rsp_data, 33'h0_0000_00AB);
        tick; rsp_ready = 0;

        // FIFO full, simultaneous push/pop, then dropped write
        put_hdr(1, 0); tick; in_valid = 0; tick;
        for (int i = 0; i < DEPTH; i++) begin pw(0, 33'(i)); tick; end
        param_write = 0;
        check("full_no_err", err_overflow, 0);
        pw(0, 33'h100); rsp_ready = 1; tick; rsp_ready = 0; param_write = 0;
        check("push_pop_full", err_overflow, 0);
        check("push_pop_head", rsp_data, 1);
        pw(0, 33'h1FF); tick; param_write = 0;
        check("full_drop", err_overflow, 1);
        cmd_done = 4'b0001; tick; cmd_done = 0;
        rsp_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            check("full_drain", rsp_data, (i < DEPTH - 1) ? 33'(i + 1) : 33'h100);
            tick;
        end
        rsp_ready = 0;
        check("full_empty", rsp_valid, 0);

        // reset clears errors and abandons a command mid-collect
        rst_n = 0; tick;
        check("rst_clr_ovf", err_overflow, 0);
        check("rst_clr_tmo", err_timeout, 0);
        rst_n = 1; tick;
        put_hdr(4, 2); tick; in_data = 32'h55; tick; in_valid = 0;
        rst_n = 0; tick; rst_n = 1; tick;
        check("abandon_a", cmd_ready, 0);
        tick;
        check("abandon_b", cmd_ready, 0);
        check("abandon_rdy", in_ready, 1);

        // write collision in WAIT_DONE
        put_hdr(6, 1); tick; in_data = 32'h77; tick; in_valid = 0;
        check("n1_pulse", cmd_ready, 1);
        check("n1_cmd", cmd, 6);
        check("n1_arg", arg_data, 32'h77);
        tick;
        param_data = '1; param_write = 4'b0011; tick; param_write = 0;
        check("collision_ovf", err_overflow, 1);
        check("collision_drop", rsp_valid, 0);
        cmd_done = 4'b0001; tick; cmd_done = 0;

        // nargs above MAX_ARGS is consumed and discarded
        rst_n = 0; tick; rst_n = 1; tick;
        put_hdr(2, 9); tick;
        check("bad_nargs_ovf", err_overflow, 1);
        check("bad_nargs_rdy", in_ready, 1);
        for (int i = 0; i < 9; i++) begin
            in_data = 32'(i); tick;
            check("bad_nargs_noissue", cmd_ready, 0);
        end
        in_valid = 0; tick;
        check("bad_nargs_idle", in_ready, 1);
        check("bad_nargs_cmd", cmd, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cmd_dispatch.md
# cmd_dispatch

Host-side end of the unit command bus: accepts framed command messages from the host word stream, buffers each message's arguments, issues it to the command units (pwm, stepper, etc.) on the shared cmd/arg bus, and waits for `cmd_done`. It also collects `param_data`/`param_write` response words from units into a response FIFO toward the host framer, and arbitrates unit involuntary-message requests (`invol_req`/`invol_grant`) so that only one source writes responses at a time.

## Interface
Parameters:
- `CMD_BITS`, 6, width of command id on the bus
- `NUNITS`, 4, number of attached command units
- `MAX_ARGS`, 8, argument buffer depth (words)
- `RSP_DEPTH`, 16, response FIFO depth (power of 2)
- `TIMEOUT`, 1024, cycles to wait for `cmd_done` before aborting

Ports:
- `clk` in 1: system clock
- `rst_n` in 1: reset; one clock, reset is asynchronous and active-low
- `in_data` in 32: host message word
- `in_valid` in 1: `in_data` valid
- `in_ready` out 1: dispatcher accepts `in_data` this cycle
- `cmd` out CMD_BITS: command id broadcast to units
- `cmd_ready` out 1: single-cycle command start pulse
- `arg_data` out 32: current argument word
- `arg_advance` in NUNITS: per-unit argument pop request (ORed)
- `cmd_done` in NUNITS: per-unit completion pulse (ORed)
- `param_data` in 33×NUNITS: unit response words, bit 32 = last word of message
- `param_write` in NUNITS: per-unit response write strobe
- `invol_req` in NUNITS: unit requests to send an unsolicited message
- `invol_grant` out NUNITS: one-hot grant
- `rsp_data` out 33: response FIFO head
- `rsp_valid` out 1 / `rsp_ready` in 1: response FIFO handshake
- `err_timeout` out 1: sticky, command never completed
- `err_overflow` out 1: sticky, response dropped (FIFO full, bad arg count, or write collision)

## Operation
- Header word: `[CMD_BITS-1:0]` = cmd id, `[15:8]` = nargs. nargs > MAX_ARGS: header consumed, nargs words discarded, `err_overflow` set, no issue.
- States: IDLE → COLLECT (nargs>0) or ISSUE (nargs=0); COLLECT → ISSUE after nargs words stored; ISSUE → WAIT_DONE; WAIT_DONE → IDLE on any `cmd_done` bit or on timeout; IDLE → INVOL when no header pending and any `invol_req`; INVOL → IDLE when granted unit's req drops.
- `in_ready` high only in IDLE and COLLECT.
- ISSUE: `cmd_ready`=1 for exactly one cycle, `arg_data`=arg[0]. Arg pointer increments at every clock edge from the ISSUE cycle on while any `arg_advance` bit is high, saturating at nargs; `arg_data`=0 when pointer ≥ nargs.
- Unknown commands complete via the unit's own `cmd_done`; dispatcher does not decode ids.
- Responses: `param_write` accepted in WAIT_DONE (any unit) and INVOL (granted unit only). Writes in other states, or more than one bit set in one cycle, are dropped and set `err_overflow`. Write to full FIFO: dropped, `err_overflow` set.
- Invol arbitration: round-robin, starting after last granted unit; pending header (`in_valid` in IDLE) has priority over invol.
- Timeout counter loads TIMEOUT at ISSUE, decrements in WAIT_DONE; reaching 0 sets `err_timeout`, returns to IDLE. Late `cmd_done` afterwards ignored.

## Timing
- Reset values: `in_ready`=0, `cmd`=0, `cmd_ready`=0, `arg_data`=0, `invol_grant`=0, `rsp_valid`=0, `rsp_data`=0, errors 0; FIFO empty, state IDLE, RR pointer 0. Reset mid-command abandons it; units see no further `cmd_ready`.
- Header accepted cycle N (nargs=k): last arg accepted N+k, `cmd_ready` at N+k+1 (N+1 for k=0).
- `cmd_done` at cycle D: IDLE at D+1, next header accepted D+1 earliest.
- Grant asserted one cycle after entering INVOL; deasserted the cycle after req drops.
- Response FIFO: write at cycle W visible on `rsp_valid` at W+1; simultaneous push/pop when full accepted (pop frees slot same cycle).

## Structure
- Shared package: header field offsets, state encoding, `RSP_WIDTH`=33, `LAST_BIT`=32.
- One sub-module: `rsp_fifo` (synchronous FIFO, 33-bit, depth RSP_DEPTH, full/empty flags).

## Test plan
- Header cmd=5 nargs=4, args 0xA..0xD; unit holds `arg_advance` → `cmd_ready` one pulse, `arg_data` sequence A,B,C,D,0; `cmd_done` → IDLE next cycle.
- nargs=0 → `cmd_ready` one cycle after header, `arg_data`=0.
- No `cmd_done` after issue → `err_timeout`=1 at TIMEOUT cycles, next header accepted.
- Unit 2 writes 3 words (last with bit 32) during WAIT_DONE, `rsp_ready`=0 → `rsp_data` holds first word; drain yields all 3 in order.
- `invol_req`=0b1010 in IDLE → grant 0b0010 first, then 0b1000 after unit 1 drops req; header arriving during INVOL waits.
- RSP_DEPTH+1 writes with `rsp_ready`=0 → last dropped, `err_overflow`=1.
